// File: rtl/mau_pkg.sv
// mau_pkg: shared types and helpers for the memory access unit.
//   size_e  - access size encoding carried on req_size
//   state_e - control FSM states of mem_access_unit
//   is_misaligned() - alignment rule for a given size and byte offset
package mau_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2,
    SZ_ILL  = 2'd3
  } size_e;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    MERGE = 3'd2,
    WRITE = 3'd3,
    ERR   = 3'd4
  } state_e;

  // Bytes are always aligned; halfwords need addr[0] = 0; words need addr[1:0] = 0.
  // The illegal size is reported separately, so it is not flagged here.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
    logic mis;
    case (size)
      SZ_HALF: mis = offset[0];
      SZ_WORD: mis = (offset != 2'b00);
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mau_lane_align.sv
// mau_lane_align: purely combinational little-endian lane handling.
//   i_word     - word read from memory
//   i_offset   - byte offset within the word (addr[1:0])
//   i_size     - access size (size_e encoding)
//   i_unsigned - zero-extend loads instead of sign-extend
//   i_wdata    - right-justified store data
//   o_rdata    - extracted and extended load result
//   o_merged   - i_word with the addressed lane replaced by store data
module mau_lane_align
  import mau_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_offset,
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_rdata,
  output logic [31:0] o_merged
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Select the addressed byte and halfword lanes
  always_comb begin
    w_byte = 8'h00;
    case (i_offset)
      2'd0:    w_byte = i_word[7:0];
      2'd1:    w_byte = i_word[15:8];
      2'd2:    w_byte = i_word[23:16];
      2'd3:    w_byte = i_word[31:24];
      default: w_byte = 8'h00;
    endcase
    if (i_offset[1]) begin
      w_half = i_word[31:16];
    end else begin
      w_half = i_word[15:0];
    end
  end

  // Extend the selected lane to a full load result
  always_comb begin
    o_rdata = 32'h0000_0000;
    case (i_size)
      SZ_BYTE: begin
        if (i_unsigned) begin
          o_rdata = {24'h00_0000, w_byte};
        end else begin
          o_rdata = {{24{w_byte[7]}}, w_byte};
        end
      end
      SZ_HALF: begin
        if (i_unsigned) begin
          o_rdata = {16'h0000, w_half};
        end else begin
          o_rdata = {{16{w_half[15]}}, w_half};
        end
      end
      SZ_WORD: o_rdata = i_word;
      default: o_rdata = 32'h0000_0000;
    endcase
  end

  // Replace the addressed lane with the low bits of the store data
  always_comb begin
    o_merged = i_word;
    case (i_size)
      SZ_BYTE: begin
        case (i_offset)
          2'd0:    o_merged = {i_word[31:8], i_wdata[7:0]};
          2'd1:    o_merged = {i_word[31:16], i_wdata[7:0], i_word[7:0]};
          2'd2:    o_merged = {i_word[31:24], i_wdata[7:0], i_word[15:0]};
          2'd3:    o_merged = {i_wdata[7:0], i_word[23:0]};
          default: o_merged = i_word;
        endcase
      end
      SZ_HALF: begin
        if (i_offset[1]) begin
          o_merged = {i_wdata[15:0], i_word[15:0]};
        end else begin
          o_merged = {i_word[31:16], i_wdata[15:0]};
        end
      end
      SZ_WORD: o_merged = i_wdata;
      default: o_merged = i_word;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store front-end between execute and a word-wide memory
// (combinational read, synchronous word write, no byte enables).
//   clk, reset            - core clock, asynchronous active-low reset
//   req_*                 - valid/ready access request (accepted only in IDLE)
//   resp_valid/rdata/error- single-cycle completion pulse with load data or error
//   mem_*                 - word-aligned memory read and write ports
// Sub-word stores are read-modify-write: MERGE reads and patches the word, WRITE
// stores it. Errors (misalignment, size 3, out of range) never touch memory.
module mem_access_unit
  import mau_pkg::*;
#(
  parameter int MEM_BYTES = 1024,
  parameter int DATA_W    = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_error,
  output logic [31:0]       mem_readaddr,
  input  logic [DATA_W-1:0] mem_readdata,
  output logic [31:0]       mem_writeaddr,
  output logic [DATA_W-1:0] mem_writedata,
  output logic              mem_writeenable
);

  state_e      r_state;
  state_e      w_next_state;
  logic [31:0] r_addr;
  logic [1:0]  r_size;
  logic        r_unsigned;
  logic        r_write;
  logic [31:0] r_wdata;

  logic        w_accept;
  logic        w_req_err;
  logic [31:0] w_word_addr;
  logic [31:0] w_rdata;
  logic [31:0] w_merged;

  assign w_accept    = req_valid && (r_state == IDLE);
  assign w_req_err   = (req_size == SZ_ILL) ||
                       is_misaligned(req_size, req_addr[1:0]) ||
                       (req_addr >= 32'(MEM_BYTES));
  assign w_word_addr = {r_addr[31:2], 2'b00};

  mau_lane_align u_lane_align (
    .i_word     (mem_readdata),
    .i_offset   (r_addr[1:0]),
    .i_size     (r_size),
    .i_unsigned (r_unsigned),
    .i_wdata    (r_wdata),
    .o_rdata    (w_rdata),
    .o_merged   (w_merged)
  );

  // Control state register; reset aborts any in-flight RMW before its write
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Request latches; in MERGE the data latch is reused to hold the patched word
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_addr     <= 32'h0000_0000;
      r_size     <= 2'b00;
      r_unsigned <= 1'b0;
      r_write    <= 1'b0;
      r_wdata    <= 32'h0000_0000;
    end else if (w_accept) begin
      r_addr     <= req_addr;
      r_size     <= req_size;
      r_unsigned <= req_unsigned;
      r_write    <= req_write;
      r_wdata    <= req_wdata;
    end else if (r_state == MERGE) begin
      r_wdata    <= w_merged;
    end
  end

  // Next-state selection; error checks are made on the request at accept time
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (req_valid) begin
          if (w_req_err) begin
            w_next_state = ERR;
          end else if (!req_write) begin
            w_next_state = LOAD;
          end else if (req_size == SZ_WORD) begin
            w_next_state = WRITE;
          end else begin
            w_next_state = MERGE;
          end
        end else begin
          w_next_state = IDLE;
        end
      end
      LOAD:    w_next_state = IDLE;
      MERGE:   w_next_state = WRITE;
      WRITE:   w_next_state = IDLE;
      ERR:     w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Output decode from the state register (drops immediately on reset)
  always_comb begin
    req_ready       = 1'b0;
    resp_valid      = 1'b0;
    resp_error      = 1'b0;
    resp_rdata      = 32'h0000_0000;
    mem_readaddr    = 32'h0000_0000;
    mem_writeaddr   = 32'h0000_0000;
    mem_writedata   = 32'h0000_0000;
    mem_writeenable = 1'b0;
    case (r_state)
      IDLE: req_ready = 1'b1;
      LOAD: begin
        mem_readaddr = w_word_addr;
        resp_valid   = 1'b1;
        if (!r_write) begin
          resp_rdata = w_rdata;
        end else begin
          resp_rdata = 32'h0000_0000;
        end
      end
      MERGE: mem_readaddr = w_word_addr;
      WRITE: begin
        mem_writeaddr   = w_word_addr;
        mem_writedata   = r_wdata;
        mem_writeenable = 1'b1;
        resp_valid      = 1'b1;
      end
      ERR: begin
        resp_valid = 1'b1;
        resp_error = 1'b1;
      end
      default: req_ready = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed, table-driven bench for mem_access_unit with a small word memory model.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_error;
  logic [31:0] mem_readaddr;
  logic [31:0] mem_readdata;
  logic [31:0] mem_writeaddr;
  logic [31:0] mem_writedata;
  logic        mem_writeenable;

  logic [31:0] mem [0:255];
  logic [31:0] wr_addr_log [0:255];
  logic [31:0] wr_data_log [0:255];
  int          wr_cnt = 0;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic        write;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    int          exp_wr;
    logic [31:0] exp_mem;
    string       name;
  } vec_t;

  vec_t vecs[$];

  mem_access_unit #(.MEM_BYTES(1024), .DATA_W(32)) dut (
    .clk             (clk),
    .reset           (reset),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_write       (req_write),
    .req_size        (req_size),
    .req_unsigned    (req_unsigned),
    .req_addr        (req_addr),
    .req_wdata       (req_wdata),
    .resp_valid      (resp_valid),
    .resp_rdata      (resp_rdata),
    .resp_error      (resp_error),
    .mem_readaddr    (mem_readaddr),
    .mem_readdata    (mem_readdata),
    .mem_writeaddr   (mem_writeaddr),
    .mem_writedata   (mem_writedata),
    .mem_writeenable (mem_writeenable)
  );

  always #5 clk = ~clk;

  assign mem_readdata = mem[mem_readaddr[9:2]];

  // Memory model: synchronous word write, plus a log of every write in order
  always @(posedge clk) begin
    if (mem_writeenable) begin
      mem[mem_writeaddr[9:2]]     <= mem_writedata;
      wr_addr_log[wr_cnt[7:0]]    <= mem_writeaddr;
      wr_data_log[wr_cnt[7:0]]    <= mem_writedata;
      wr_cnt                      <= wr_cnt + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic add(input logic wr, input logic [1:0] sz, input logic uns,
                     input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [31:0] erd, input logic eerr, input int elat,
                     input int ewr, input logic [31:0] emem, input string name);
    vec_t v;
    v.write = wr; v.size = sz; v.uns = uns; v.addr = addr; v.wdata = wdata;
    v.exp_rdata = erd; v.exp_err = eerr; v.exp_lat = elat; v.exp_wr = ewr;
    v.exp_mem = emem; v.name = name;
    vecs.push_back(v);
  endtask

  // Starts at a negedge with the DUT idle; ends at a negedge with the DUT idle.
  task automatic do_req(input vec_t v);
    int wr0;
    int lat;
    wr0 = wr_cnt;
    chk({v.name, "_ready"}, {31'h0, req_ready}, 32'h1);
    req_valid    = 1'b1;
    req_write    = v.write;
    req_size     = v.size;
    req_unsigned = v.uns;
    req_addr     = v.addr;
    req_wdata    = v.wdata;
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 6) begin
      @(negedge clk);
      lat++;
    end
    chk({v.name, "_latency"}, 32'(lat), 32'(v.exp_lat));
    chk({v.name, "_rdata"}, resp_rdata, v.exp_rdata);
    chk({v.name, "_error"}, {31'h0, resp_error}, {31'h0, v.exp_err});
    chk({v.name, "_we"}, {31'h0, mem_writeenable}, (v.exp_wr != 0) ? 32'h1 : 32'h0);
    if (!v.write && !v.exp_err) begin
      chk({v.name, "_readaddr"}, mem_readaddr, {v.addr[31:2], 2'b00});
    end
    @(negedge clk);
    chk({v.name, "_pulse_once"}, {31'h0, resp_valid}, 32'h0);
    chk({v.name, "_writes"}, 32'(wr_cnt - wr0), 32'(v.exp_wr));
    if (v.exp_wr != 0) begin
      chk({v.name, "_mem"}, mem[v.addr[9:2]], v.exp_mem);
    end
  endtask

  initial begin
    int wr0;
    int idx;
    int npulse;
    int acc_cyc [0:3];
    logic rdy;
    vec_t v;

    reset = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0;
    req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;

    // Table: write, size, unsigned, addr, wdata, rdata, err, latency, writes, mem
    add(1'b1, 2'd2, 1'b0, 32'h40,  32'hDEADBEEF, 32'h0,        1'b0, 1, 1, 32'hDEADBEEF, "sw_40");
    add(1'b0, 2'd2, 1'b0, 32'h40,  32'h0,        32'hDEADBEEF, 1'b0, 1, 0, 32'h0,        "lw_40");
    add(1'b1, 2'd2, 1'b0, 32'h40,  32'h8070F0FF, 32'h0,        1'b0, 1, 1, 32'h8070F0FF, "sw_40b");
    add(1'b0, 2'd0, 1'b0, 32'h40,  32'h0,        32'hFFFFFFFF, 1'b0, 1, 0, 32'h0,        "lb_40");
    add(1'b0, 2'd0, 1'b1, 32'h41,  32'h0,        32'h000000F0, 1'b0, 1, 0, 32'h0,        "lbu_41");
    add(1'b0, 2'd1, 1'b0, 32'h42,  32'h0,        32'hFFFF8070, 1'b0, 1, 0, 32'h0,        "lh_42");
    add(1'b0, 2'd1, 1'b1, 32'h42,  32'h0,        32'h00008070, 1'b0, 1, 0, 32'h0,        "lhu_42");
    add(1'b1, 2'd2, 1'b0, 32'h40,  32'h11223344, 32'h0,        1'b0, 1, 1, 32'h11223344, "sw_40c");
    add(1'b1, 2'd0, 1'b0, 32'h42,  32'hFFFFFF5A, 32'h0,        1'b0, 2, 1, 32'h115A3344, "sb_42");
    add(1'b1, 2'd1, 1'b0, 32'h40,  32'h1234BEEF, 32'h0,        1'b0, 2, 1, 32'h115ABEEF, "sh_40");
    add(1'b0, 2'd2, 1'b0, 32'h41,  32'h0,        32'h0,        1'b1, 1, 0, 32'h0,        "lw_41_err");
    add(1'b0, 2'd1, 1'b0, 32'h43,  32'h0,        32'h0,        1'b1, 1, 0, 32'h0,        "lh_43_err");
    add(1'b0, 2'd3, 1'b0, 32'h40,  32'h0,        32'h0,        1'b1, 1, 0, 32'h0,        "size3_err");
    add(1'b0, 2'd2, 1'b0, 32'h400, 32'h0,        32'h0,        1'b1, 1, 0, 32'h0,        "lw_400_err");
    add(1'b1, 2'd1, 1'b0, 32'h41,  32'hFFFF,     32'h0,        1'b1, 1, 0, 32'h0,        "sh_41_err");
    add(1'b1, 2'd2, 1'b0, 32'h400, 32'h12345678, 32'h0,        1'b1, 1, 0, 32'h0,        "sw_400_err");
    add(1'b1, 2'd3, 1'b0, 32'h40,  32'h0,        32'h0,        1'b1, 1, 0, 32'h0,        "st_size3_err");
    add(1'b0, 2'd2, 1'b0, 32'h40,  32'h0,        32'h115ABEEF, 1'b0, 1, 0, 32'h0,        "lw_40_after");
    add(1'b0, 2'd1, 1'b1, 32'h40,  32'h0,        32'h0000BEEF, 1'b0, 1, 0, 32'h0,        "lhu_40");
    add(1'b0, 2'd1, 1'b0, 32'h40,  32'h0,        32'hFFFFBEEF, 1'b0, 1, 0, 32'h0,        "lh_40");
    add(1'b0, 2'd0, 1'b0, 32'h43,  32'h0,        32'h00000011, 1'b0, 1, 0, 32'h0,        "lb_43");
    add(1'b0, 2'd0, 1'b1, 32'h42,  32'h0,        32'h0000005A, 1'b0, 1, 0, 32'h0,        "lbu_42");
    add(1'b1, 2'd2, 1'b0, 32'h3FC, 32'hCAFEF00D, 32'h0,        1'b0, 1, 1, 32'hCAFEF00D, "sw_3fc");
    add(1'b0, 2'd0, 1'b0, 32'h3FF, 32'h0,        32'hFFFFFFCA, 1'b0, 1, 0, 32'h0,        "lb_3ff");
    add(1'b1, 2'd2, 1'b0, 32'h44,  32'h55667788, 32'h0,        1'b0, 1, 1, 32'h55667788, "sw_44");

    // Reset state
    #12;
    chk("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
    chk("rst_resp_error", {31'h0, resp_error}, 32'h0);
    chk("rst_resp_rdata", resp_rdata, 32'h0);
    chk("rst_we", {31'h0, mem_writeenable}, 32'h0);
    chk("rst_readaddr", mem_readaddr, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_ready_after", {31'h0, req_ready}, 32'h1);

    foreach (vecs[i]) begin
      do_req(vecs[i]);
    end

    // Reset asserted while a byte store to 0x44 is in MERGE
    wr0 = wr_cnt;
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = 32'h44; req_wdata = 32'h000000AA;
    @(negedge clk);
    req_valid = 1'b0;
    chk("merge_no_resp", {31'h0, resp_valid}, 32'h0);
    chk("merge_no_we", {31'h0, mem_writeenable}, 32'h0);
    chk("merge_readaddr", mem_readaddr, 32'h44);
    #1 reset = 1'b0;
    #1;
    chk("rstmid_we", {31'h0, mem_writeenable}, 32'h0);
    chk("rstmid_resp_valid", {31'h0, resp_valid}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rstmid_ready", {31'h0, req_ready}, 32'h1);
    chk("rstmid_no_write", 32'(wr_cnt - wr0), 32'h0);
    chk("rstmid_mem_44", mem[8'h11], 32'h55667788);
    v.write = 1'b0; v.size = 2'd2; v.uns = 1'b0; v.addr = 32'h44; v.wdata = 32'h0;
    v.exp_rdata = 32'h55667788; v.exp_err = 1'b0; v.exp_lat = 1; v.exp_wr = 0;
    v.exp_mem = 32'h0; v.name = "lw_44_after_rst";
    do_req(v);

    // req_valid held high over four word stores
    wr0 = wr_cnt; npulse = 0; idx = 0;
    for (int i = 0; i < 4; i++) acc_cyc[i] = -1;
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'd2; req_unsigned = 1'b0;
    req_addr = 32'h80; req_wdata = 32'hB0B00000;
    for (int cyc = 0; cyc < 16; cyc++) begin
      if (resp_valid) npulse++;
      rdy = req_ready;
      @(negedge clk);
      if (rdy && idx < 4) begin
        acc_cyc[idx] = cyc;
        idx++;
        if (idx < 4) begin
          req_addr  = 32'h80 + 32'(4 * idx);
          req_wdata = 32'hB0B00000 + 32'(idx);
        end else begin
          req_valid = 1'b0;
        end
      end
    end
    chk("b2b_accepts", 32'(idx), 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("b2b_accept_cycle_%0d", i), 32'(acc_cyc[i]), 32'(2 * i));
    end
    chk("b2b_pulses", 32'(npulse), 32'd4);
    chk("b2b_writes", 32'(wr_cnt - wr0), 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("b2b_wr_addr_%0d", i), wr_addr_log[8'(wr0 + i)], 32'h80 + 32'(4 * i));
      chk($sformatf("b2b_wr_data_%0d", i), wr_data_log[8'(wr0 + i)], 32'hB0B00000 + 32'(i));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
